// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI3 single-beat SRAM slave: response codes,
// one-hot read/write FSM encodings and the optional back-pressure LFSR setup.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_MEM  = 3'b010,
        R_RESP = 3'b100
    } r_state_e;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_MEM  = 3'b010,
        W_RESP = 3'b100
    } w_state_e;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Single-port word RAM: synchronous 1-cycle read, per-byte write enables.
// The array has no reset so contents survive a slave reset.
module axi_slave_ram #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic              clk,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << MEM_AW) - 1];

    // Byte-lane writes and registered read; rdata only changes on a read
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-beat slave in front of an on-chip word RAM. One read and one
// write may be outstanding; bursts and out-of-range addresses get SLVERR.
// Optional random back-pressure: define AXI_SLAVE_DELAY_EN.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // Bursts and anything outside the RAM window are rejected
    function automatic logic req_err(input logic [31:0] a, input logic [7:0] len);
        return (len != 8'd0) || (a[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
    endfunction

    r_state_e r_state, r_state_nx;
    w_state_e w_state, w_state_nx;

    logic              alive;
    logic [3:0]        r_id;
    logic [MEM_AW-1:0] r_idx;
    logic              r_err;
    logic [3:0]        b_id;
    logic [MEM_AW-1:0] w_idx;
    logic              w_err;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              aw_got, w_got;
    logic              ar_hs, aw_hs, w_hs;

    logic              ram_re;
    logic [3:0]        ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_rdata;

    logic gate_ar, gate_aw, gate_w, gate_r, gate_b;

    logic unused_inputs;
    assign unused_inputs = ^{arsize, awsize, wid, wlast, araddr[1:0], awaddr[1:0]};

`ifdef AXI_SLAVE_DELAY_EN
    logic [7:0] lfsr;
    logic       r_shown, b_shown;

    // Free-running back-pressure pattern
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    // A valid that was shown but not taken must stay up until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shown <= 1'b0;
            b_shown <= 1'b0;
        end else begin
            r_shown <= rvalid & ~rready;
            b_shown <= bvalid & ~bready;
        end
    end

    assign gate_ar = lfsr[0];
    assign gate_aw = lfsr[1];
    assign gate_w  = lfsr[2];
    assign gate_r  = lfsr[3] | r_shown;
    assign gate_b  = lfsr[4] | b_shown;
`else
    assign gate_ar = 1'b1;
    assign gate_aw = 1'b1;
    assign gate_w  = 1'b1;
    assign gate_r  = 1'b1;
    assign gate_b  = 1'b1;
`endif

    // Holds readies low during reset and for the edge that releases it
    always_ff @(posedge clk) begin
        if (reset) alive <= 1'b0;
        else       alive <= 1'b1;
    end

    assign arready = alive & (r_state == R_IDLE) & gate_ar;
    assign awready = alive & (w_state == W_IDLE) & ~aw_got & gate_aw;
    assign wready  = alive & (w_state == W_IDLE) & ~w_got & gate_w;

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // ---------------------------------------------------------------- read

    // Read state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_nx;
    end

    // Read next-state and rvalid; W_MEM owns the RAM so R_MEM waits for it
    always_comb begin
        r_state_nx = r_state;
        rvalid     = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_state_nx = R_MEM;
            R_MEM:  if (w_state != W_MEM) r_state_nx = R_RESP;
            R_RESP: begin
                rvalid = gate_r;
                if (gate_r && rready) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Capture read request attributes on the AR handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id  <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (ar_hs) begin
            r_id  <= arid;
            r_idx <= araddr[MEM_AW+1:2];
            r_err <= req_err(araddr, arlen);
        end
    end

    assign rid   = r_id;
    assign rlast = 1'b1;
    assign rdata = (r_state == R_RESP && !r_err) ? ram_rdata : '0;
    assign rresp = (r_state == R_RESP && r_err) ? RESP_SLVERR : RESP_OKAY;

    // --------------------------------------------------------------- write

    // Write state register
    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_nx;
    end

    // Write next-state and bvalid; a same-cycle handshake counts as held
    // so the later of AW/W still reaches bvalid two cycles on
    always_comb begin
        w_state_nx = w_state;
        bvalid     = 1'b0;
        unique case (w_state)
            W_IDLE: if ((aw_got || aw_hs) && (w_got || w_hs)) w_state_nx = W_MEM;
            W_MEM:  w_state_nx = W_RESP;
            W_RESP: begin
                bvalid = gate_b;
                if (gate_b && bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // AW and W are captured independently and released on the B handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_id   <= '0;
            w_idx  <= '0;
            w_err  <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (bvalid && bready) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                b_id   <= awid;
                w_idx  <= awaddr[MEM_AW+1:2];
                w_err  <= req_err(awaddr, awlen);
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    assign bid   = b_id;
    assign bresp = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

    // ----------------------------------------------------------------- RAM

    assign ram_we   = (w_state == W_MEM && !w_err) ? w_strb : '0;
    assign ram_re   = (r_state == R_MEM) && (w_state != W_MEM) && !r_err;
    assign ram_addr = (w_state == W_MEM) ? w_idx : r_idx;

    axi_slave_ram #(
        .MEM_AW(MEM_AW)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_rdata)
    );

endmodule
